muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative multiply/divide unit for the EX stage of the MIPS datapath. It takes the same `operandA`/`operandB` buses the ALU receives and executes `mult`, `multu`, `div` and `divu` over 33 cycles. Results go into architectural HI/LO registers, which are read downstream through the EX result mux for `mfhi`/`mflo`. The hazard unit uses `busy` to stall the pipeline.

## Interface
- Parameters: none. Width is fixed at 32.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `resetN`  in  1  reset, synchronous, active-low.
- `start`  in  1  begin an operation. Sampled only while `busy`=0.
- `op`  in  2  operation: 00 `mult`, 01 `multu`, 10 `div`, 11 `divu`. Sampled with `start`.
- `operandA`  in  32  multiplicand or dividend (rs). Sampled with `start`.
- `operandB`  in  32  multiplier or divisor (rt). Sampled with `start`.
- `hiWrite`  in  1  `mthi`: write `writeData` into HI.
- `loWrite`  in  1  `mtlo`: write `writeData` into LO.
- `writeData`  in  32  data for `mthi`/`mtlo`.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse: HI/LO were just updated by an operation.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- States:
  - IDLE → RUN when `start`=1.
  - RUN → FIX after 32 iterations.
  - FIX → IDLE unconditionally.
- At start, the unit latches `op` and the operand magnitudes.
  - Signed ops (`mult`, `div`) take the absolute value of each operand.
  - It also latches the result sign = A[31]^B[31] and the remainder sign = A[31].
  - A 6-bit counter is loaded with 32.
- RUN, multiply: shift-add, one multiplier bit per cycle, into a 64-bit accumulator.
- RUN, divide: restoring division, one quotient bit per cycle. The remainder register is 33 bits.
- FIX, sign correction (signed ops only):
  - Product negated (64-bit two's complement) if the result sign is 1.
  - Quotient negated if the result sign is 1.
  - Remainder negated if A[31]=1, so the remainder sign follows the dividend.
- FIX, writeback:
  - Multiply: HI ← product[63:32], LO ← product[31:0].
  - Divide: LO ← quotient, HI ← remainder.
- Divide by zero (B=0, signed or unsigned): LO=0xFFFFFFFF, HI=`operandA` as sampled. Full 33-cycle latency still applies.
- Signed overflow, `div` 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0x00000000.
- `hiWrite`/`loWrite`:
  - Take effect at the next edge, only while `busy`=0 and FIX is not active.
  - Ignored while `busy`=1; the hazard unit guarantees stalls.
  - If `start` and a write occur in the same cycle, both are honoured. The later FIX writeback overwrites.
- `start` while `busy`=1 is ignored. No queueing.
- Operand or `op` changes after the start edge have no effect.

## Timing
- Edge 0 samples `start`=1.
- `busy`=1 after edge 0 through edge 32.
- Edges 1–32 are RUN iterations.
- Edge 33 is the FIX writeback.
- After edge 33: `busy`=0, `done`=1 for exactly one cycle, and `hi`/`lo` hold the new values.
- Latency from start to valid HI/LO is 33 cycles.
- A new `start` is accepted in the cycle `done`=1, giving back-to-back operations every 34 cycles.
- `hi`/`lo` hold their previous values throughout RUN. No partial results are visible.
- Reset (`resetN`=0 at an edge, including mid-operation):
  - State IDLE, counter 0, `busy`=0, `done`=0, `hi`=0, `lo`=0.
  - The in-flight operation is discarded with no writeback.
  - `start` is ignored during reset.
- Outputs are registered. No combinational path from inputs to outputs.

## Test plan
- `multu` A=0xFFFFFFFF, B=0xFFFFFFFF → at edge 33: `done`=1, HI=0xFFFFFFFE, LO=0x00000001. `busy` high exactly 33 cycles.
- `mult` A=-23, B=67 → HI=0xFFFFFFFF, LO=0xFFFFF9FB.
- `div` A=-44, B=5 → LO=0xFFFFFFF8 (-8), HI=0xFFFFFFFC (-4).
- `divu` A=90, B=7 → LO=12, HI=6.
- Edge cases:
  - `div` A=0x80000000, B=0xFFFFFFFF → LO=0x80000000, HI=0.
  - `divu` A=90, B=0 → LO=0xFFFFFFFF, HI=90.
  - Both keep 33-cycle latency.
- Control/reset:
  - Second `start` (different operands) at cycle 5 of a `multu` is ignored; first result unchanged.
  - `mthi` 0x1234 while idle gives `hi`=0x1234 next cycle; `mtlo` while busy is ignored.
  - `resetN`=0 at cycle 10 of a `div`: `busy`/`done`/HI/LO all 0, and no `done` pulse follows.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative 32x32 multiply / divide unit (mult, multu, div, divu) with HI/LO registers.
// Latency: 33 cycles from the start edge to the HI/LO writeback; done pulses for one cycle afterwards.
// Backpressure: busy stays high for the whole operation; start and mthi/mtlo are ignored while busy.
module muldiv_unit (
    input  logic        clk,
    input  logic        resetN,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] operandA,
    input  logic [31:0] operandB,
    input  logic        hiWrite,
    input  logic        loWrite,
    input  logic [31:0] writeData,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [1:0]  op_q, op_d;
    // Multiply: {partial product, remaining multiplier bits}. Divide: low half is dividend -> quotient.
    logic [63:0] acc_q, acc_d;
    logic [32:0] rem_q, rem_d;
    logic [31:0] bmag_q, bmag_d;
    logic [31:0] a_raw_q, a_raw_d;
    logic        rsign_q, rsign_d;
    logic        remsign_q, remsign_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    // Datapath temporaries
    logic        start_signed;
    logic [31:0] amag_in, bmag_in;
    logic [32:0] mul_sum;
    logic [33:0] div_shift;
    logic [34:0] div_diff;
    logic        op_signed;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix;

    // Next-state, iteration datapath and writeback selection
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        bmag_d    = bmag_q;
        a_raw_d   = a_raw_q;
        rsign_d   = rsign_q;
        remsign_d = remsign_q;
        done_d    = 1'b0;
        hi_d      = hi_q;
        lo_d      = lo_q;

        // op[0]=0 selects the signed flavour (mult / div)
        start_signed = ~op[0];
        amag_in      = (start_signed && operandA[31]) ? (~operandA + 32'd1) : operandA;
        bmag_in      = (start_signed && operandB[31]) ? (~operandB + 32'd1) : operandB;

        mul_sum   = {1'b0, acc_q[63:32]} + {1'b0, bmag_q};
        div_shift = {rem_q, acc_q[31]};
        div_diff  = {1'b0, div_shift} - {3'b000, bmag_q};

        op_signed = ~op_q[0];
        prod_fix  = (op_signed && rsign_q)   ? (~acc_q + 64'd1)        : acc_q;
        quo_fix   = (op_signed && rsign_q)   ? (~acc_q[31:0] + 32'd1)  : acc_q[31:0];
        rem_fix   = (op_signed && remsign_q) ? (~rem_q[31:0] + 32'd1)  : rem_q[31:0];

        case (state_q)
            ST_IDLE: begin
                // Architectural moves are honoured even in the same cycle as start
                if (hiWrite) hi_d = writeData;
                if (loWrite) lo_d = writeData;
                if (start) begin
                    state_d   = ST_RUN;
                    cnt_d     = 6'd32;
                    op_d      = op;
                    acc_d     = {32'd0, amag_in};
                    rem_d     = 33'd0;
                    bmag_d    = bmag_in;
                    a_raw_d   = operandA;
                    rsign_d   = operandA[31] ^ operandB[31];
                    remsign_d = operandA[31];
                end
            end
            ST_RUN: begin
                if (!op_q[1]) begin
                    // Shift-add: add multiplicand when the current multiplier bit is set
                    if (acc_q[0]) acc_d = {mul_sum, acc_q[31:1]};
                    else          acc_d = {1'b0, acc_q[63:1]};
                end else begin
                    // Restoring division: keep the trial subtraction only if it did not go negative
                    if (!div_diff[34]) begin
                        rem_d = div_diff[32:0];
                        acc_d = {acc_q[63:32], acc_q[30:0], 1'b1};
                    end else begin
                        rem_d = div_shift[32:0];
                        acc_d = {acc_q[63:32], acc_q[30:0], 1'b0};
                    end
                end
                cnt_d = cnt_q - 6'd1;
                if (cnt_q == 6'd1) state_d = ST_FIX;
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                if (!op_q[1]) begin
                    hi_d = prod_fix[63:32];
                    lo_d = prod_fix[31:0];
                end else if (bmag_q == 32'd0) begin
                    // Divide by zero: all-ones quotient, dividend passed through as remainder
                    hi_d = a_raw_q;
                    lo_d = 32'hFFFF_FFFF;
                end else begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 6'd0;
            op_q      <= 2'd0;
            acc_q     <= 64'd0;
            rem_q     <= 33'd0;
            bmag_q    <= 32'd0;
            a_raw_q   <= 32'd0;
            rsign_q   <= 1'b0;
            remsign_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            acc_q     <= acc_d;
            rem_q     <= rem_d;
            bmag_q    <= bmag_d;
            a_raw_q   <= a_raw_d;
            rsign_q   <= rsign_d;
            remsign_q <= remsign_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

    logic        clk;
    logic        resetN;
    logic        start;
    logic [1:0]  op;
    logic [31:0] operandA;
    logic [31:0] operandB;
    logic        hiWrite;
    logic        loWrite;
    logic [31:0] writeData;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int pass_cnt = 0;
    int total_cnt = 0;

    muldiv_unit dut (
        .clk       (clk),
        .resetN    (resetN),
        .start     (start),
        .op        (op),
        .operandA  (operandA),
        .operandB  (operandB),
        .hiWrite   (hiWrite),
        .loWrite   (loWrite),
        .writeData (writeData),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Reference behaviour from plain integer arithmetic
    function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] eh, output logic [31:0] el);
        logic [63:0] p;
        int sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        eh = 32'd0;
        el = 32'd0;
        case (o)
            2'd0: begin
                p  = {{32{a[31]}}, a} * {{32{b[31]}}, b};
                eh = p[63:32];
                el = p[31:0];
            end
            2'd1: begin
                p  = {32'd0, a} * {32'd0, b};
                eh = p[63:32];
                el = p[31:0];
            end
            2'd2: begin
                if (b == 32'd0) begin
                    eh = a; el = 32'hFFFF_FFFF;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    eh = 32'd0; el = 32'h8000_0000;
                end else begin
                    el = sa / sb;
                    eh = sa % sb;
                end
            end
            default: begin
                if (b == 32'd0) begin
                    eh = a; el = 32'hFFFF_FFFF;
                end else begin
                    el = a / b;
                    eh = a % b;
                end
            end
        endcase
    endfunction

    // Runs one operation. mode 1: second start at cycle 5; mode 2: mtlo attempt while busy.
    task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input int mode);
        logic [31:0] eh, el, pre_hi, pre_lo;
        int lat, busy_cycles;
        bit held;
        model(o, a, b, eh, el);
        @(negedge clk);
        start = 1'b1; op = o; operandA = a; operandB = b;
        @(posedge clk); #1;
        check({tag, "_busy_edge0"}, {63'd0, busy}, 64'd1);
        check({tag, "_done_edge0"}, {63'd0, done}, 64'd0);
        pre_hi = hi; pre_lo = lo;
        busy_cycles = 1;
        @(negedge clk);
        // Later operand/op changes must not disturb the operation
        start = 1'b0; op = 2'($urandom); operandA = $urandom; operandB = $urandom;
        lat = 0;
        held = 1'b1;
        while (lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (busy) busy_cycles++;
            if (done) break;
            if (hi !== pre_hi || lo !== pre_lo) held = 1'b0;
            if (mode == 1 && lat == 4) begin
                start = 1'b1; op = 2'd1; operandA = 32'd3; operandB = 32'd5;
            end
            if (mode == 1 && lat == 5) start = 1'b0;
            if (mode == 2 && lat == 2) begin
                loWrite = 1'b1; writeData = 32'hDEAD_BEEF;
            end
            if (mode == 2 && lat == 3) loWrite = 1'b0;
        end
        check({tag, "_latency"}, 64'(lat), 64'd33);
        check({tag, "_busy_cycles"}, 64'(busy_cycles), 64'd33);
        check({tag, "_busy_after"}, {63'd0, busy}, 64'd0);
        check({tag, "_hold_during_run"}, {63'd0, held}, 64'd1);
        check({tag, "_hi"}, {32'd0, hi}, {32'd0, eh});
        check({tag, "_lo"}, {32'd0, lo}, {32'd0, el});
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        int seen_done;

        resetN = 1'b0; start = 1'b0; op = 2'd0; operandA = 32'd0; operandB = 32'd0;
        hiWrite = 1'b0; loWrite = 1'b0; writeData = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_hi", {32'd0, hi}, 64'd0);
        check("reset_lo", {32'd0, lo}, 64'd0);
        @(negedge clk);
        resetN = 1'b1;

        // Directed cases
        do_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        check("multu_max_hi_const", {32'd0, hi}, 64'h0000_0000_FFFF_FFFE);
        check("multu_max_lo_const", {32'd0, lo}, 64'h0000_0000_0000_0001);
        @(posedge clk); #1;
        check("done_one_cycle", {63'd0, done}, 64'd0);
        do_op("mult_neg", 2'd0, 32'hFFFF_FFE9, 32'd67, 0);
        check("mult_neg_lo_const", {32'd0, lo}, 64'h0000_0000_FFFF_F9FB);
        // Back-to-back: each next op starts in the done cycle of the previous
        do_op("div_neg", 2'd2, 32'hFFFF_FFD4, 32'd5, 0);
        check("div_neg_lo_const", {32'd0, lo}, 64'h0000_0000_FFFF_FFF8);
        check("div_neg_hi_const", {32'd0, hi}, 64'h0000_0000_FFFF_FFFC);
        do_op("divu_90_7", 2'd3, 32'd90, 32'd7, 0);
        do_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        do_op("divu_by0", 2'd3, 32'd90, 32'd0, 0);
        do_op("div_by0", 2'd2, 32'hFFFF_FF00, 32'd0, 0);
        do_op("multu_2nd_start", 2'd1, 32'h1234_5678, 32'h9ABC_DEF0, 1);

        // mthi while idle
        @(negedge clk);
        hiWrite = 1'b1; writeData = 32'h0000_1234;
        @(posedge clk); #1;
        check("mthi_idle", {32'd0, hi}, 64'h0000_0000_0000_1234);
        @(negedge clk);
        hiWrite = 1'b0;
        // mtlo while busy must be dropped
        do_op("mtlo_busy", 2'd1, 32'd7, 32'd9, 2);

        // Random operations, occasionally with special divisors
        for (int i = 0; i < 20; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 15));
                2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                default: ;
            endcase
            do_op("rand", ro, ra, rb, 0);
        end

        // Reset in the middle of a divide
        @(negedge clk);
        start = 1'b1; op = 2'd2; operandA = 32'd1000; operandB = 32'd3;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        resetN = 1'b0;
        @(posedge clk); #1;
        check("midreset_busy", {63'd0, busy}, 64'd0);
        check("midreset_done", {63'd0, done}, 64'd0);
        check("midreset_hi", {32'd0, hi}, 64'd0);
        check("midreset_lo", {32'd0, lo}, 64'd0);
        @(negedge clk);
        resetN = 1'b1;
        seen_done = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done || busy) seen_done++;
        end
        check("midreset_no_done", 64'(seen_done), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
